// File: rtl/sha256d_nonce_scheduler_pkg.sv
// Shared constants, state encoding and helpers for the SHA-256d nonce scheduler.
// The scheduler drives an external compression core that returns chain + compression.
package sha256d_nonce_scheduler_pkg;

  localparam int DIGEST_W = 256;
  localparam int BLOCK_W  = 512;

  localparam logic [255:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] PAD_WORD   = 32'h80000000;
  localparam logic [63:0] LEN_HDR    = 64'd640;
  localparam logic [63:0] LEN_DIGEST = 64'd256;

  typedef enum logic [3:0] {
    IDLE,
    MID_REQ,
    MID_WAIT,
    H1_REQ,
    H1_WAIT,
    H2_REQ,
    H2_WAIT,
    CHECK,
    REPORT,
    NEXT,
    DRAIN,
    FINISH
  } state_e;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/sha256d_target_cmp.sv
// Byte-reverses a SHA-256d digest into the numeric hash value and compares it
// against the difficulty target (match when strictly below).
module sha256d_target_cmp
  import sha256d_nonce_scheduler_pkg::*;
(
  input  logic [DIGEST_W-1:0] digest,
  input  logic [DIGEST_W-1:0] target,
  output logic                match
);

  logic [DIGEST_W-1:0] cmp_value;

  for (genvar gi = 0; gi < DIGEST_W / 8; gi++) begin : g_rev
    assign cmp_value[8*gi +: 8] = digest[8*(DIGEST_W/8-1-gi) +: 8];
  end

  assign match = (cmp_value < target);

endmodule

// File: rtl/sha256d_nonce_scheduler.sv
// Walks an inclusive nonce range, issuing MID/H1/H2 compressions to an external
// SHA-256 core and reporting every nonce whose double hash beats the target.
module sha256d_nonce_scheduler
  import sha256d_nonce_scheduler_pkg::*;
#(
  parameter int MIDSTATE_EN = 1
) (
  input  logic         CLK,
  input  logic         nreset,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [639:0] job_header,
  input  logic [31:0]  job_nonce_lo,
  input  logic [31:0]  job_nonce_hi,
  input  logic [255:0] job_target,
  input  logic         abort,
  output logic         core_start,
  output logic         core_use_iv,
  output logic [255:0] core_chain,
  output logic [511:0] core_block,
  input  logic         core_done,
  input  logic [255:0] core_digest,
  output logic         found_valid,
  input  logic         found_ready,
  output logic [31:0]  found_nonce,
  output logic [255:0] found_hash,
  output logic         busy,
  output logic         job_done,
  output logic         exhausted,
  output logic [31:0]  hash_count
);

  state_e         state_q, state_d;
  logic [607:0]   hdr_q, hdr_d;  // header bytes 0..75; the nonce field is replaced by the scan
  logic [31:0]    nonce_q, nonce_d;
  logic [31:0]    nonce_hi_q, nonce_hi_d;
  logic [255:0]   target_q, target_d;
  logic [255:0]   midstate_q, midstate_d;
  logic [255:0]   h1_q, h1_d;
  logic [255:0]   h2_q, h2_d;
  logic           use_iv_q, use_iv_d;
  logic [255:0]   chain_q, chain_d;
  logic [511:0]   block_q, block_d;
  logic           exhausted_q, exhausted_d;
  logic [31:0]    hash_count_q, hash_count_d;
  logic           h2_match;
  logic [31:0]    hdr_nonce_unused;

  assign hdr_nonce_unused = job_header[31:0];

  sha256d_target_cmp u_cmp (
    .digest (h2_q),
    .target (target_q),
    .match  (h2_match)
  );

  always_comb begin
    state_d      = state_q;
    hdr_d        = hdr_q;
    nonce_d      = nonce_q;
    nonce_hi_d   = nonce_hi_q;
    target_d     = target_q;
    midstate_d   = midstate_q;
    h1_d         = h1_q;
    h2_d         = h2_q;
    use_iv_d     = use_iv_q;
    chain_d      = chain_q;
    block_d      = block_q;
    exhausted_d  = exhausted_q;
    hash_count_d = hash_count_q;

    unique case (state_q)
      IDLE: begin
        if (job_valid) begin
          hdr_d        = job_header[639:32];
          nonce_d      = job_nonce_lo;
          nonce_hi_d   = job_nonce_hi;
          target_d     = job_target;
          hash_count_d = '0;
          if (job_nonce_hi < job_nonce_lo) begin
            exhausted_d = 1'b1;
            state_d     = FINISH;
          end else begin
            exhausted_d = 1'b0;
            state_d     = MID_REQ;
          end
        end
      end
      MID_REQ: state_d = abort ? FINISH : MID_WAIT;
      H1_REQ:  state_d = abort ? FINISH : H1_WAIT;
      H2_REQ:  state_d = abort ? FINISH : H2_WAIT;
      // An abort coinciding with completion has nothing left to drain.
      MID_WAIT: begin
        if (abort) state_d = core_done ? FINISH : DRAIN;
        else if (core_done) begin
          midstate_d = core_digest;
          state_d    = H1_REQ;
        end
      end
      H1_WAIT: begin
        if (abort) state_d = core_done ? FINISH : DRAIN;
        else if (core_done) begin
          h1_d    = core_digest;
          state_d = H2_REQ;
        end
      end
      H2_WAIT: begin
        if (abort) state_d = core_done ? FINISH : DRAIN;
        else if (core_done) begin
          h2_d    = core_digest;
          state_d = CHECK;
        end
      end
      CHECK: begin
        hash_count_d = (hash_count_q == 32'hFFFFFFFF) ? hash_count_q : hash_count_q + 32'd1;
        if (abort)         state_d = FINISH;
        else if (h2_match) state_d = REPORT;
        else               state_d = NEXT;
      end
      REPORT: begin
        if (found_ready) state_d = NEXT;
        else if (abort)  state_d = FINISH;
      end
      NEXT: begin
        if (abort) state_d = FINISH;
        else if (nonce_q == nonce_hi_q) begin
          exhausted_d = 1'b1;
          state_d     = FINISH;
        end else begin
          nonce_d = nonce_q + 32'd1;
          state_d = (MIDSTATE_EN != 0) ? H1_REQ : MID_REQ;
        end
      end
      DRAIN:   if (core_done) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Request payload is captured on entry to a *_REQ state and held through the wait.
    if (state_d != state_q) begin
      case (state_d)
        MID_REQ: begin
          use_iv_d = 1'b1;
          chain_d  = SHA256_IV;
          block_d  = hdr_d[607:96];
        end
        H1_REQ: begin
          use_iv_d = 1'b0;
          chain_d  = midstate_d;
          block_d  = {hdr_d[95:0], bswap32(nonce_d), PAD_WORD, 288'b0, LEN_HDR};
        end
        H2_REQ: begin
          use_iv_d = 1'b1;
          chain_d  = SHA256_IV;
          block_d  = {h1_d, PAD_WORD, 160'b0, LEN_DIGEST};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nreset) begin
    if (!nreset) begin
      state_q      <= IDLE;
      hdr_q        <= '0;
      nonce_q      <= '0;
      nonce_hi_q   <= '0;
      target_q     <= '0;
      midstate_q   <= '0;
      h1_q         <= '0;
      h2_q         <= '0;
      use_iv_q     <= 1'b0;
      chain_q      <= '0;
      block_q      <= '0;
      exhausted_q  <= 1'b0;
      hash_count_q <= '0;
    end else begin
      state_q      <= state_d;
      hdr_q        <= hdr_d;
      nonce_q      <= nonce_d;
      nonce_hi_q   <= nonce_hi_d;
      target_q     <= target_d;
      midstate_q   <= midstate_d;
      h1_q         <= h1_d;
      h2_q         <= h2_d;
      use_iv_q     <= use_iv_d;
      chain_q      <= chain_d;
      block_q      <= block_d;
      exhausted_q  <= exhausted_d;
      hash_count_q <= hash_count_d;
    end
  end

  assign job_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign core_start  = (state_q inside {MID_REQ, H1_REQ, H2_REQ}) && !abort;
  assign core_use_iv = use_iv_q;
  assign core_chain  = chain_q;
  assign core_block  = block_q;
  assign found_valid = (state_q == REPORT);
  assign found_nonce = found_valid ? nonce_q : '0;
  assign found_hash  = found_valid ? h2_q : '0;
  assign job_done    = (state_q == FINISH);
  assign exhausted   = exhausted_q;
  assign hash_count  = hash_count_q;

endmodule

// File: tb/tb_sha256d_nonce_scheduler.sv
// Directed bench: two schedulers (midstate reuse on/off), each with a behavioural
// SHA-256 compression core that answers requests after a fixed latency.
module tb_sha256d_nonce_scheduler;

  localparam int LAT = 3;

  localparam logic [255:0] H0 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [639:0] GEN_HDR = 640'h01000000_0000000000000000000000000000000000000000000000000000000000000000_3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a_29ab5f49_ffff001d_1dac2b7c;
  localparam logic [255:0] GEN_HASH = 256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;
  localparam logic [255:0] GEN_TGT  = 256'hffff << 208;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, hh} = h;
    for (int i = 0; i < 64; i++) begin
      t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
            h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
  endfunction

  // Bitcoin double SHA-256 of an 80-byte header with the nonce field replaced.
  function automatic logic [255:0] sha256d_ref(input logic [639:0] hdr, input logic [31:0] nonce);
    logic [255:0] h1;
    logic [639:0] msg;
    msg = {hdr[639:32], nonce[7:0], nonce[15:8], nonce[23:16], nonce[31:24]};
    h1  = sha_compress(H0, msg[639:128]);
    h1  = sha_compress(h1, {msg[127:0], 32'h80000000, 288'b0, 64'd640});
    return sha_compress(H0, {h1, 32'h80000000, 160'b0, 64'd256});
  endfunction

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic         nreset;
  logic         job_valid [2];
  logic         found_ready [2];
  logic [639:0] job_header;
  logic [31:0]  job_nonce_lo, job_nonce_hi;
  logic [255:0] job_target;
  logic         abort;

  logic         job_ready_w [2], core_start_w [2], core_use_iv_w [2];
  logic [255:0] core_chain_w [2];
  logic [511:0] core_block_w [2];
  logic         found_valid_w [2], busy_w [2], job_done_w [2], exhausted_w [2];
  logic [31:0]  found_nonce_w [2], hash_count_w [2];
  logic [255:0] found_hash_w [2];

  int           start_a [2], h2_a [2], found_a [2], stall_a [2], stab_a [2];
  logic [31:0]  last_nonce_a [2];
  logic [255:0] last_hash_a [2];
  time          last_done_a [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    logic         core_done = 1'b0;
    logic [255:0] core_digest = '0;
    int           start_cnt = 0, h2_cnt = 0, found_cnt = 0, stall_cnt = 0, stab_cnt = 0;
    logic [31:0]  last_nonce = '0;
    logic [255:0] last_hash = '0;
    time          last_done_t = 0;

    sha256d_nonce_scheduler #(.MIDSTATE_EN((gi == 0) ? 1 : 0)) u_dut (
      .CLK          (CLK),
      .nreset       (nreset),
      .job_valid    (job_valid[gi]),
      .job_ready    (job_ready_w[gi]),
      .job_header   (job_header),
      .job_nonce_lo (job_nonce_lo),
      .job_nonce_hi (job_nonce_hi),
      .job_target   (job_target),
      .abort        (abort),
      .core_start   (core_start_w[gi]),
      .core_use_iv  (core_use_iv_w[gi]),
      .core_chain   (core_chain_w[gi]),
      .core_block   (core_block_w[gi]),
      .core_done    (core_done),
      .core_digest  (core_digest),
      .found_valid  (found_valid_w[gi]),
      .found_ready  (found_ready[gi]),
      .found_nonce  (found_nonce_w[gi]),
      .found_hash   (found_hash_w[gi]),
      .busy         (busy_w[gi]),
      .job_done     (job_done_w[gi]),
      .exhausted    (exhausted_w[gi]),
      .hash_count   (hash_count_w[gi])
    );

    initial begin : core_model
      logic         pend;
      int           cnt;
      logic         uiv;
      logic [255:0] chn, res;
      logic [511:0] blk;
      pend = 1'b0; cnt = 0; uiv = 1'b0; chn = '0; res = '0; blk = '0;
      forever begin
        @(negedge CLK); #1;
        if (found_valid_w[gi] && found_ready[gi]) begin
          found_cnt++;
          last_nonce = found_nonce_w[gi];
          last_hash  = found_hash_w[gi];
        end
        if (found_valid_w[gi] && core_start_w[gi]) stall_cnt++;
        if (pend && (core_block_w[gi] !== blk || core_chain_w[gi] !== chn || core_use_iv_w[gi] !== uiv))
          stab_cnt++;
        core_done = 1'b0;
        if (pend) begin
          if (cnt == 0) begin
            core_done   = 1'b1;
            core_digest = res;
            pend        = 1'b0;
            last_done_t = $time;
          end else cnt--;
        end
        if (core_start_w[gi]) begin
          if (pend) stab_cnt++;
          pend = 1'b1;
          cnt  = LAT;
          blk  = core_block_w[gi];
          chn  = core_chain_w[gi];
          uiv  = core_use_iv_w[gi];
          res  = sha_compress(uiv ? H0 : chn, blk);
          start_cnt++;
          if (uiv && blk[63:0] == 64'd256) h2_cnt++;
        end
      end
    end

    assign start_a[gi]      = start_cnt;
    assign h2_a[gi]         = h2_cnt;
    assign found_a[gi]      = found_cnt;
    assign stall_a[gi]      = stall_cnt;
    assign stab_a[gi]       = stab_cnt;
    assign last_nonce_a[gi] = last_nonce;
    assign last_hash_a[gi]  = last_hash;
    assign last_done_a[gi]  = last_done_t;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Called on a negedge with the targeted schedulers idle; returns one cycle after acceptance.
  task automatic send_job(input logic m0, input logic m1, input logic [31:0] lo,
                          input logic [31:0] hi, input logic [255:0] tgt);
    job_header   = GEN_HDR;
    job_nonce_lo = lo;
    job_nonce_hi = hi;
    job_target   = tgt;
    job_valid[0] = m0;
    job_valid[1] = m1;
    @(negedge CLK);
    job_valid[0] = 1'b0;
    job_valid[1] = 1'b0;
  endtask

  task automatic wait_done(input int inst, input int budget, input string tag);
    int n;
    n = 0;
    while (job_done_w[inst] !== 1'b1 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check({tag, "_job_done"}, job_done_w[inst], 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, s1, h0, f0, st0;
    int n;
    logic [31:0] obs_nonce;
    logic [255:0] obs_hash;
    logic stable;
    time t_abort;

    nreset = 1'b0;
    job_valid[0] = 1'b0; job_valid[1] = 1'b0;
    found_ready[0] = 1'b1; found_ready[1] = 1'b1;
    abort = 1'b0;
    job_header = GEN_HDR; job_nonce_lo = '0; job_nonce_hi = '0; job_target = '0;
    tick(3);
    check("rst_job_ready", job_ready_w[0], 1'b1);
    check("rst_busy", busy_w[0], 1'b0);
    check("rst_core_start", core_start_w[0], 1'b0);
    check("rst_found_valid", found_valid_w[0], 1'b0);
    check("rst_job_done", job_done_w[0], 1'b0);
    check("rst_exhausted", exhausted_w[0], 1'b0);
    check("rst_hash_count", hash_count_w[0], 32'd0);
    check("rst_core_block", core_block_w[0], 512'd0);
    nreset = 1'b1;
    tick(2);

    // Genesis block: single winning nonce inside a 7-nonce window.
    s0 = start_a[0]; h0 = h2_a[0]; f0 = found_a[0];
    send_job(1'b1, 1'b0, 32'h7C2BAC1A, 32'h7C2BAC20, GEN_TGT);
    check("gen_busy", busy_w[0], 1'b1);
    check("gen_job_ready_low", job_ready_w[0], 1'b0);
    wait_done(0, 400, "gen");
    check("gen_found_count", found_a[0] - f0, 32'd1);
    check("gen_found_nonce", last_nonce_a[0], 32'h7C2BAC1D);
    check("gen_found_hash", last_hash_a[0], GEN_HASH);
    check("gen_exhausted", exhausted_w[0], 1'b1);
    check("gen_hash_count", hash_count_w[0], 32'd7);
    check("gen_h2_reqs", h2_a[0] - h0, 32'd7);
    check("gen_core_reqs", start_a[0] - s0, 32'd15);
    tick(1);
    check("gen_job_done_pulse", job_done_w[0], 1'b0);
    check("gen_idle_ready", job_ready_w[0], 1'b1);
    check("gen_exhausted_held", exhausted_w[0], 1'b1);

    // Empty range: straight to FINISH, no core traffic.
    s0 = start_a[0];
    send_job(1'b1, 1'b0, 32'd5, 32'd4, GEN_TGT);
    check("empty_job_done", job_done_w[0], 1'b1);
    check("empty_exhausted", exhausted_w[0], 1'b1);
    check("empty_hash_count", hash_count_w[0], 32'd0);
    tick(5);
    check("empty_no_core_start", start_a[0] - s0, 32'd0);
    check("empty_ready", job_ready_w[0], 1'b1);

    // Top of nonce space, target 0: no match and no wrap past 0xFFFFFFFF.
    s0 = start_a[0]; h0 = h2_a[0]; f0 = found_a[0];
    send_job(1'b1, 1'b0, 32'hFFFFFFFE, 32'hFFFFFFFF, 256'd0);
    wait_done(0, 200, "top");
    check("top_h2_reqs", h2_a[0] - h0, 32'd2);
    check("top_core_reqs", start_a[0] - s0, 32'd5);
    check("top_exhausted", exhausted_w[0], 1'b1);
    check("top_hash_count", hash_count_w[0], 32'd2);
    check("top_no_found", found_a[0] - f0, 32'd0);
    tick(20);
    check("top_no_wrap", start_a[0] - s0, 32'd5);

    // All-ones target with a 20-cycle found_ready stall.
    found_ready[0] = 1'b0;
    s0 = start_a[0]; f0 = found_a[0];
    send_job(1'b1, 1'b0, 32'd10, 32'd12, {256{1'b1}});
    n = 0;
    while (found_valid_w[0] !== 1'b1 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check("stall_found_valid", found_valid_w[0], 1'b1);
    obs_nonce = found_nonce_w[0];
    obs_hash  = found_hash_w[0];
    check("stall_found_nonce", obs_nonce, 32'd10);
    check("stall_found_hash", obs_hash, sha256d_ref(GEN_HDR, 32'd10));
    st0 = stall_a[0]; s1 = start_a[0];
    stable = 1'b1;
    repeat (20) begin
      @(negedge CLK);
      if (found_valid_w[0] !== 1'b1 || found_nonce_w[0] !== obs_nonce || found_hash_w[0] !== obs_hash)
        stable = 1'b0;
    end
    check("stall_outputs_stable", stable, 1'b1);
    check("stall_no_core_start", start_a[0] - s1, 32'd0);
    check("stall_no_start_while_found", stall_a[0] - st0, 32'd0);
    found_ready[0] = 1'b1;
    wait_done(0, 300, "stall");
    check("stall_found_count", found_a[0] - f0, 32'd3);
    check("stall_last_nonce", last_nonce_a[0], 32'd12);
    check("stall_last_hash", last_hash_a[0], sha256d_ref(GEN_HDR, 32'd12));
    check("stall_hash_count", hash_count_w[0], 32'd3);
    check("stall_exhausted", exhausted_w[0], 1'b1);
    check("stall_core_reqs", start_a[0] - s0, 32'd7);
    tick(1);

    // Abort while the H1 compression is in flight.
    send_job(1'b1, 1'b0, 32'd100, 32'd200, 256'd0);
    n = 0;
    while (!(core_start_w[0] === 1'b1 && core_use_iv_w[0] === 1'b0) && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check("abort_h1_seen", core_start_w[0] && !core_use_iv_w[0], 1'b1);
    tick(1);
    abort = 1'b1;
    t_abort = $time;
    s0 = start_a[0];
    @(negedge CLK);
    abort = 1'b0;
    check("abort_drain_busy", busy_w[0], 1'b1);
    check("abort_drain_no_done", job_done_w[0], 1'b0);
    wait_done(0, 50, "abort");
    check("abort_exhausted", exhausted_w[0], 1'b0);
    check("abort_no_new_start", start_a[0] - s0, 32'd0);
    check("abort_waited_core_done", last_done_a[0] > t_abort, 1'b1);
    check("abort_idle_ignored", job_ready_w[1], 1'b1);
    tick(1);

    // Midstate reuse versus per-nonce recomputation over three nonces.
    s0 = start_a[0]; s1 = start_a[1];
    send_job(1'b1, 1'b1, 32'h20, 32'h22, 256'd0);
    wait_done(0, 300, "mid_on");
    check("mid_on_core_reqs", start_a[0] - s0, 32'd7);
    check("mid_on_hash_count", hash_count_w[0], 32'd3);
    wait_done(1, 300, "mid_off");
    check("mid_off_core_reqs", start_a[1] - s1, 32'd9);
    check("mid_off_hash_count", hash_count_w[1], 32'd3);
    check("mid_off_exhausted", exhausted_w[1], 1'b1);
    tick(2);
    check("payload_stability_0", stab_a[0], 32'd0);
    check("payload_stability_1", stab_a[1], 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
